// File: rtl/mont_mult.sv
// Bit-serial radix-2 Montgomery multiplier: R_out = A*B*2^-WIDTH mod Prime.
// Define MONT_ERR_CHECK_EN to add the err port and reject even/zero moduli.
module mont_mult #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_sig,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic [WIDTH-1:0] Prime,
  output logic [WIDTH-1:0] R_out,
  output logic             done,
  output logic             busy
`ifdef MONT_ERR_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam int SW = WIDTH + 2;

  typedef enum logic [1:0] {IDLE, CALC, FINAL, OUT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, b;
  logic [SW-1:0]    s;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] a_red, b_red, s_red;
  logic [SW-1:0]    p_ext, t_add, t_odd, s_nxt;
  logic             start;
`ifdef MONT_ERR_CHECK_EN
  logic             prime_bad;
`endif

  always_comb begin
    p_ext = {2'b00, Prime};
    a_red = (A_i >= Prime) ? A_i - Prime : A_i;
    b_red = (B_i >= Prime) ? B_i - Prime : B_i;
    // S < 2P and b < P keep t_odd below 4P, so WIDTH+2 bits never overflow
    t_add = s + (a[cnt] ? {2'b00, b} : '0);
    t_odd = t_add[0] ? t_add + p_ext : t_add;
    s_nxt = t_odd >> 1;
    s_red = (s >= p_ext) ? WIDTH'(s - p_ext) : s[WIDTH-1:0];
    start = (state == IDLE) && in_sig;
  end

`ifdef MONT_ERR_CHECK_EN
  assign prime_bad = ~Prime[0];
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_sig) begin
`ifdef MONT_ERR_CHECK_EN
          state_nxt = prime_bad ? OUT : CALC;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FINAL;
      FINAL:   state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a     <= '0;
      b     <= '0;
      s     <= '0;
      cnt   <= '0;
      R_out <= '0;
      done  <= 1'b0;
`ifdef MONT_ERR_CHECK_EN
      err   <= 1'b0;
`endif
    end else begin
      if (start) begin
        a   <= a_red;
        b   <= b_red;
        s   <= '0;
        cnt <= '0;
`ifdef MONT_ERR_CHECK_EN
        err <= prime_bad;
        if (prime_bad) begin
          R_out <= '0;
          done  <= 1'b1;
        end
`endif
      end
      case (state)
        CALC: begin
          s   <= s_nxt;
          cnt <= cnt + 1'b1;
        end
        FINAL: begin
          R_out <= s_red;
          done  <= 1'b1;
        end
        OUT:     done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mult.sv
// Directed self-checking bench for mont_mult (WIDTH=32); MONT_ERR_CHECK_EN adds err checks.
module tb_mont_mult;
  localparam int W = 32;
  localparam logic [W-1:0] PB = 32'hFFFF_FFFB;

  logic         clk = 1'b0;
  logic         reset, in_sig, done, busy;
  logic [W-1:0] a_i, b_i, prime, r_out;
`ifdef MONT_ERR_CHECK_EN
  logic         err;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  mont_mult #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .in_sig(in_sig),
    .A_i   (a_i),
    .B_i   (b_i),
    .Prime (prime),
    .R_out (r_out),
    .done  (done),
    .busy  (busy)
`ifdef MONT_ERR_CHECK_EN
    ,
    .err   (err)
`endif
  );

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Returns #1 after the start edge; inputs are scrambled afterwards.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] p);
    int guard = 0;
    while (busy && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (busy) check("idle_wait", 32'(busy), 32'd0);
    @(negedge clk);
    a_i = a; b_i = b; prime = p; in_sig = 1'b1;
    @(posedge clk); #1;
    in_sig = 1'b0;
    a_i = ~a;
    b_i = b ^ 32'h5A5A_5A5A;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    start_op(v.a, v.b, v.p);
    wait_done(lat);
    check({name, "_lat"}, 32'(lat), 32'd33);
    check(name, r_out, v.exp);
    @(posedge clk); #1;
    check({name, "_done_w"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int busy_err, done_cnt, done_at, stray;

    vecs[0]  = '{32'd5,          32'h1234_5678, PB,    32'h1234_5678};
    vecs[1]  = '{32'd25,         32'd1,         PB,    32'd5};
    vecs[2]  = '{32'd5,          32'd5,         PB,    32'd5};
    vecs[3]  = '{32'hFFFF_FFFF,  32'd25,        PB,    32'h14};
    vecs[4]  = '{32'd0,          32'hABCD_EF01, PB,    32'd0};
    vecs[5]  = '{32'd1,          32'd25,        PB,    32'd5};
    vecs[6]  = '{32'd25,         32'd25,        PB,    32'd125};
    vecs[7]  = '{32'd5,          32'hFFFF_FFFA, PB,    32'hFFFF_FFFA};
    vecs[8]  = '{32'd5,          PB,            PB,    32'd0};
    vecs[9]  = '{32'hFFFF_FFFE,  32'd25,        PB,    32'd15};
    vecs[10] = '{32'd9,          32'd7,         32'd13, 32'd7};
    vecs[11] = '{32'd12,         32'd12,        32'd13, 32'd3};

    reset = 1'b0; in_sig = 1'b0; a_i = '0; b_i = '0; prime = PB;
    repeat (2) @(posedge clk);
    #1;
    check("rst_r_out", r_out, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // in_sig while busy must be ignored
    start_op(32'd5, 32'h1234_5678, PB);
    busy_err = busy ? 0 : 1;
    done_cnt = 0;
    done_at  = -1;
    for (int n = 1; n <= 40; n++) begin
      if (n == 10) begin
        @(negedge clk);
        in_sig = 1'b1; a_i = 32'd25; b_i = 32'd1;
      end
      @(posedge clk); #1;
      in_sig = 1'b0;
      if (busy !== (n <= 33)) busy_err++;
      if (done) begin
        done_cnt++;
        done_at = n;
      end
    end
    check("busy_profile", 32'(busy_err), 32'd0);
    check("busy_done_cnt", 32'(done_cnt), 32'd1);
    check("busy_done_at", 32'(done_at), 32'd33);
    check("busy_r_out", r_out, 32'h1234_5678);

    // asynchronous reset mid-CALC
    start_op(32'd25, 32'd1, PB);
    repeat (15) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_r_out", r_out, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    stray = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy) stray++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) stray++;
    end
    check("mid_rst_quiet", 32'(stray), 32'd0);
    run_vec("after_rst", vecs[1]);

`ifdef MONT_ERR_CHECK_EN
    start_op(32'd5, 32'd5, 32'h10);
    check("err_done", 32'(done), 32'd1);
    check("err_flag", 32'(err), 32'd1);
    check("err_r_out", r_out, 32'd0);
    @(posedge clk); #1;
    check("err_done_w", 32'(done), 32'd0);
    check("err_hold", 32'(err), 32'd1);
    start_op(32'd5, 32'h1234_5678, PB);
    check("err_clear", 32'(err), 32'd0);
    begin
      int lat;
      wait_done(lat);
      check("err_next_lat", 32'(lat), 32'd33);
      check("err_next_r_out", r_out, 32'h1234_5678);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
